pc_fetch_ctrl: RTL and testbench

//  Next-generation fetch front end: generates the next PC, issues instruction-address

---
 rtl/pc_fetch_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch front end -- next-PC generation, request handshake, in-order kill queue.
// Optional define PC_ADEL_CHECK_EN: misaligned PCs become address-error entries instead of fetches.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR      = 32'hbfc00000,
  parameter logic [31:0] EXCEPT_ADDR     = 32'hbfc00380,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        jsrc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] jr_target,
  input  logic [31:0] j_target,
  input  logic [31:0] br_addr,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        ex_int_handle,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_inst,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel,
  output logic        out_abnormal,
  input  logic        out_ready
);

  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [QW-1:0] PTR_LAST = QW'(MAX_OUTSTANDING - 1);

  logic                       rst_q;
  logic [31:0]                pc_q, pc_d;
  logic                       abn_pend_q, abn_pend_d;
  logic [MAX_OUTSTANDING-1:0] q_vld_q, q_vld_d;
  logic [MAX_OUTSTANDING-1:0] q_kill_q, q_kill_d;
  logic [MAX_OUTSTANDING-1:0] q_abn_q, q_abn_d;
  logic [31:0]                q_pc_q [MAX_OUTSTANDING];
  logic [31:0]                q_pc_d [MAX_OUTSTANDING];
  logic [QW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                       out_valid_q, out_valid_d;
  logic [31:0]                out_pc_q, out_pc_d;
  logic [31:0]                out_inst_q, out_inst_d;
  logic                       out_adel_q, out_adel_d;
  logic                       out_abn_q, out_abn_d;
`ifdef PC_ADEL_CHECK_EN
  logic                       adel_done_q, adel_done_d;
`endif

  logic        queue_full, queue_empty, live_any, out_hold, pc_misaligned;
  logic        issue, pop, redirect;
  logic [31:0] redirect_pc;

  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign queue_full  = &q_vld_q;
  assign queue_empty = ~|q_vld_q;
  assign live_any    = |(q_vld_q & ~q_kill_q);
  // A live fetch will land in the output register; stop issuing while it is occupied.
  assign out_hold    = out_valid_q && !out_ready && live_any;
`ifdef PC_ADEL_CHECK_EN
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  assign req_valid = !rst_q && !queue_full && !out_hold && !pc_misaligned;
  assign req_addr  = pc_q;
  assign issue     = req_valid && req_ready;
  assign pop       = resp_valid && !queue_empty;

  always_comb begin
    redirect    = 1'b1;
    redirect_pc = EXCEPT_ADDR;
    if (ex_int_handle) begin
      redirect_pc = EXCEPT_ADDR;
    end else if (eret) begin
      redirect_pc = epc;
    end else if (pc_write && pcsrc == 2'd1) begin
      redirect_pc = jsrc ? jr_target : j_target;
    end else if (pc_write && pcsrc == 2'd2) begin
      redirect_pc = br_addr;
    end else begin
      redirect    = 1'b0;
      redirect_pc = pc_q;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    abn_pend_d  = abn_pend_q;
    q_vld_d     = q_vld_q;
    q_kill_d    = q_kill_q;
    q_abn_d     = q_abn_q;
    q_pc_d      = q_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_adel_d  = out_adel_q;
    out_abn_d   = out_abn_q;
`ifdef PC_ADEL_CHECK_EN
    adel_done_d = adel_done_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (pop) begin
      q_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
      if (!q_kill_q[rd_ptr_q]) begin
        out_valid_d = 1'b1;
        out_pc_d    = q_pc_q[rd_ptr_q];
        out_inst_d  = resp_inst;
        out_adel_d  = 1'b0;
        out_abn_d   = q_abn_q[rd_ptr_q];
      end
    end

`ifdef PC_ADEL_CHECK_EN
    // Report the bad PC once, after older fetches have drained; only a redirect re-arms it.
    if (pc_misaligned && !adel_done_q && queue_empty && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_q;
      out_inst_d  = '0;
      out_adel_d  = 1'b1;
      out_abn_d   = abn_pend_q;
      abn_pend_d  = 1'b0;
      adel_done_d = 1'b1;
    end
`endif

    if (issue) begin
      q_vld_d[wr_ptr_q]  = 1'b1;
      q_kill_d[wr_ptr_q] = 1'b0;
      q_abn_d[wr_ptr_q]  = abn_pend_q;
      q_pc_d[wr_ptr_q]   = pc_q;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
      pc_d               = pc_q + 32'd4;
      abn_pend_d         = 1'b0;
    end

    // Killing every slot also covers an entry pushed this cycle; free slots are rewritten on push.
    if (redirect) begin
      pc_d        = redirect_pc;
      q_kill_d    = '1;
      out_valid_d = 1'b0;
      out_pc_d    = '0;
      out_inst_d  = '0;
      out_adel_d  = 1'b0;
      out_abn_d   = 1'b0;
      abn_pend_d  = ex_int_handle | eret;
`ifdef PC_ADEL_CHECK_EN
      adel_done_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pc_q        <= RESET_ADDR;
      abn_pend_q  <= 1'b0;
      q_vld_q     <= '0;
      q_kill_q    <= '0;
      q_abn_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_adel_q  <= 1'b0;
      out_abn_q   <= 1'b0;
`ifdef PC_ADEL_CHECK_EN
      adel_done_q <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      abn_pend_q  <= abn_pend_d;
      q_vld_q     <= q_vld_d;
      q_kill_q    <= q_kill_d;
      q_abn_q     <= q_abn_d;
      q_pc_q      <= q_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_adel_q  <= out_adel_d;
      out_abn_q   <= out_abn_d;
`ifdef PC_ADEL_CHECK_EN
      adel_done_q <= adel_done_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_inst     = out_inst_q;
  assign out_adel     = out_adel_q;
  assign out_abnormal = out_abn_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: random + directed bench for pc_fetch_ctrl against a queue-based fetch model.
// The bus side is emulated here; responses never land on a held output register.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR  = 32'hbfc00000;
  localparam logic [31:0] EXCEPT_ADDR = 32'hbfc00380;
  localparam int          MAXO        = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0, jsrc = 1'b0, eret = 1'b0, ex_int_handle = 1'b0;
  logic [1:0]  pcsrc = 2'd0;
  logic [31:0] jr_target = '0, j_target = '0, br_addr = '0, epc = '0;
  logic        req_ready = 1'b0, resp_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] resp_inst = '0;
  logic        req_valid, out_valid, out_adel, out_abnormal;
  logic [31:0] req_addr, out_pc, out_inst;

  pc_fetch_ctrl #(.RESET_ADDR(RESET_ADDR), .EXCEPT_ADDR(EXCEPT_ADDR), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .jsrc(jsrc), .pcsrc(pcsrc),
    .jr_target(jr_target), .j_target(j_target), .br_addr(br_addr), .eret(eret), .epc(epc),
    .ex_int_handle(ex_int_handle), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_inst(resp_inst),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_adel(out_adel),
    .out_abnormal(out_abnormal), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit kill; bit abn; } fly_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; bit abn; } del_t;

  fly_t        bus_q[$];
  del_t        exp_out[$];
  logic [31:0] exp_pc = RESET_ADDR;
  bit          abn_pend = 1'b0, rst_q_m = 1'b0;
  int          n_tests = 0, n_fail = 0;
  bit          chk_en = 1'b0, resp_en = 1'b0, force_resp = 1'b0;
  int          resp_pct = 100;
  logic [31:0] iss_log[$];
  logic [31:0] del_pc_log[$];
  bit          del_abn_log[$];
  int          iss_cnt = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (bus_q[i]) if (!bus_q[i].kill) n++;
    return n;
  endfunction

  function automatic bit pred_req();
    return !rst_q_m && bus_q.size() < MAXO && !(exp_out.size() != 0 && !out_ready && live_cnt() > 0);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the fetch stream is a PC that advances by 4 per accepted request and jumps on redirect;
  // in-flight requests are killed by any later redirect; one output slot.
  always @(posedge clk) begin
    bit          iss, redir;
    logic [31:0] tgt;
    fly_t        e;
    if (rst) begin
      bus_q.delete();
      exp_out.delete();
      exp_pc   = RESET_ADDR;
      abn_pend = 1'b0;
    end else begin
      iss   = pred_req() && req_ready;
      redir = 1'b1;
      tgt   = EXCEPT_ADDR;
      if (ex_int_handle)                  tgt = EXCEPT_ADDR;
      else if (eret)                      tgt = epc;
      else if (pc_write && pcsrc == 2'd1) tgt = jsrc ? jr_target : j_target;
      else if (pc_write && pcsrc == 2'd2) tgt = br_addr;
      else                                redir = 1'b0;
      if (exp_out.size() != 0 && out_ready) void'(exp_out.pop_front());
      if (resp_valid && bus_q.size() != 0) begin
        e = bus_q.pop_front();
        if (!e.kill && !redir) exp_out.push_back('{pc: e.addr, inst: inst_of(e.addr), abn: e.abn});
      end
      if (iss) bus_q.push_back('{addr: exp_pc, kill: 1'b0, abn: abn_pend});
      if (redir) begin
        foreach (bus_q[i]) bus_q[i].kill = 1'b1;
        exp_out.delete();
        exp_pc   = tgt;
        abn_pend = ex_int_handle | eret;
      end else if (iss) begin
        exp_pc   = exp_pc + 32'd4;
        abn_pend = 1'b0;
      end
    end
    rst_q_m = rst;
  end

  task automatic cyc();
    if (force_resp) begin
      resp_valid = 1'b1;
      resp_inst  = 32'hdeadbeef;
    end else if (resp_en && bus_q.size() != 0 && !(exp_out.size() != 0 && !out_ready) &&
                 $urandom_range(99) < resp_pct) begin
      resp_valid = 1'b1;
      resp_inst  = inst_of(bus_q[0].addr);
    end else begin
      resp_valid = 1'b0;
      resp_inst  = $urandom;
    end
    #1;
    if (chk_en) begin
      check_val("req_valid", req_valid, pred_req());
      if (pred_req()) check_val("req_addr", req_addr, exp_pc);
      check_val("out_valid", out_valid, exp_out.size() != 0);
      if (exp_out.size() != 0) begin
        check_val("out_pc", out_pc, exp_out[0].pc);
        check_val("out_inst", out_inst, exp_out[0].inst);
        check_val("out_abnormal", out_abnormal, exp_out[0].abn);
      end
      check_val("out_adel", out_adel, 1'b0);
    end
    if (req_valid && req_ready) begin
      iss_log.push_back(req_addr);
      iss_cnt++;
    end
    if (out_valid && out_ready) begin
      del_pc_log.push_back(out_pc);
      del_abn_log.push_back(out_abnormal);
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    req_ready     = ($urandom_range(3) != 0);
    out_ready     = ($urandom_range(3) != 0);
    pc_write      = ($urandom_range(4) != 0);
    jsrc          = $urandom_range(1);
    ex_int_handle = ($urandom_range(49) == 0);
    eret          = ($urandom_range(49) == 0);
    case ($urandom_range(5))
      3:       pcsrc = 2'd1;
      4:       pcsrc = 2'd2;
      5:       pcsrc = 2'd3;
      default: pcsrc = 2'd0;
    endcase
    jr_target = $urandom & 32'hfffffffc;
    j_target  = $urandom & 32'hfffffffc;
    br_addr   = $urandom & 32'hfffffffc;
    epc       = $urandom & 32'hfffffffc;
  endtask

  task automatic quiet_inputs();
    pc_write = 1'b0; pcsrc = 2'd0; eret = 1'b0; ex_int_handle = 1'b0; jsrc = 1'b0;
  endtask

  initial begin
    int          k;
    logic [31:0] hold_pc, hold_inst;
    @(negedge clk);
    repeat (3) cyc();
    check_val("rst_req_valid", req_valid, 1'b0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_pc", out_pc, 32'h0);
    check_val("rst_out_inst", out_inst, 32'h0);
    check_val("rst_out_adel", out_adel, 1'b0);
    check_val("rst_out_abn", out_abnormal, 1'b0);
    chk_en = 1'b1;

    // sequential fetch from the reset vector
    rst = 1'b0; iss_log.delete();
    req_ready = 1'b1; out_ready = 1'b1; resp_en = 1'b1; resp_pct = 100;
    repeat (12) cyc();
    check_val("t1_n_issued", iss_log.size() >= 3, 1'b1);
    if (iss_log.size() >= 3) begin
      check_val("t1_addr0", iss_log[0], 32'hbfc00000);
      check_val("t1_addr1", iss_log[1], 32'hbfc00004);
      check_val("t1_addr2", iss_log[2], 32'hbfc00008);
    end

    // queue depth limit with responses withheld
    req_ready = 1'b0;
    repeat (6) cyc();
    iss_cnt = 0; req_ready = 1'b1; resp_en = 1'b0;
    repeat (8) cyc();
    check_val("t2_issue_count", iss_cnt, 32'd2);
    check_val("t2_req_valid", req_valid, 1'b0);

    // branch kills both in-flight fetches
    iss_log.delete(); del_pc_log.delete(); del_abn_log.delete();
    pc_write = 1'b1; pcsrc = 2'd2; br_addr = 32'h80001000;
    cyc();
    quiet_inputs(); resp_en = 1'b1;
    repeat (10) cyc();
    check_val("t3_n_issued", iss_log.size() != 0, 1'b1);
    if (iss_log.size() != 0) check_val("t3_first_req", iss_log[0], 32'h80001000);
    check_val("t3_n_deliv", del_pc_log.size() != 0, 1'b1);
    if (del_pc_log.size() != 0) check_val("t3_first_deliv", del_pc_log[0], 32'h80001000);

    // exception beats eret beats jump
    ex_int_handle = 1'b1; eret = 1'b1; pc_write = 1'b1; pcsrc = 2'd1;
    epc = 32'h80002000; j_target = 32'h80003000;
    cyc();
    quiet_inputs();
    iss_log.delete(); del_pc_log.delete(); del_abn_log.delete();
    repeat (12) cyc();
    check_val("t4_n_issued", iss_log.size() != 0, 1'b1);
    if (iss_log.size() != 0) check_val("t4_first_req", iss_log[0], 32'hbfc00380);
    check_val("t4_n_deliv", del_pc_log.size() >= 2, 1'b1);
    if (del_pc_log.size() >= 2) begin
      check_val("t4_deliv0_pc", del_pc_log[0], 32'hbfc00380);
      check_val("t4_deliv0_abn", del_abn_log[0], 1'b1);
      check_val("t4_deliv1_pc", del_pc_log[1], 32'hbfc00384);
      check_val("t4_deliv1_abn", del_abn_log[1], 1'b0);
    end

    // consumer stall: output must hold steady
    k = 0;
    while (exp_out.size() == 0 && k < 30) begin cyc(); k++; end
    check_val("t5_have_output", exp_out.size() != 0, 1'b1);
    hold_pc   = (exp_out.size() != 0) ? exp_out[0].pc : 32'h0;
    hold_inst = (exp_out.size() != 0) ? exp_out[0].inst : 32'h0;
    out_ready = 1'b0;
    repeat (5) cyc();
    check_val("t5_valid_held", out_valid, 1'b1);
    check_val("t5_pc_held", out_pc, hold_pc);
    check_val("t5_inst_held", out_inst, hold_inst);
    out_ready = 1'b1;
    repeat (10) cyc();

    // reset mid-stream, stray responses afterwards
    req_ready = 1'b0; rst = 1'b1; force_resp = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    force_resp = 1'b0;
    check_val("mid_rst_out_valid", out_valid, 1'b0);
    req_ready = 1'b1;
    repeat (20) cyc();

    resp_pct = 60;
    repeat (2500) begin
      rand_inputs();
      cyc();
    end
    quiet_inputs(); req_ready = 1'b1; out_ready = 1'b1; resp_pct = 100;
    repeat (10) cyc();

`ifdef PC_ADEL_CHECK_EN
    chk_en = 1'b0;
    jsrc = 1'b1; jr_target = 32'h80000002; pc_write = 1'b1; pcsrc = 2'd1;
    cyc();
    quiet_inputs();
    iss_cnt = 0; k = 0;
    while (!(out_valid && out_adel) && k < 20) begin cyc(); k++; end
    check_val("t6_adel", out_adel, 1'b1);
    check_val("t6_pc", out_pc, 32'h80000002);
    check_val("t6_inst", out_inst, 32'h0);
    check_val("t6_no_issue", iss_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
